// File: rtl/instr_fetch_32.sv
// Instruction fetch stage: holds the fetch PC, issues one word request at a
// time on the imem request/grant/response port, and presents the fetched
// instruction with its PC and pre-sliced register fields to the decoder.
module instr_fetch_32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode_o,
  output logic [4:0]  instr_rd_o,
  output logic [4:0]  instr_rs1_o,
  output logic [4:0]  instr_rs2_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        discard_q, discard_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        req;

  // The low two bits of the redirect target are always forced to zero.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // State register and output register, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  // Next-state, request and output-register update; redirect overrides last.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    req        = 1'b0;

    // Decoder takes the held instruction whenever it is not stalled.
    if (valid_q && !stall_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        // Only fetch when the output register will be free for the response.
        req = !valid_q || !stall_i;
        if (req && imem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
          if (discard_q) begin
            discard_d = 1'b0;
          end else begin
            instr_d    = imem_rdata_i;
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (redirect_i) begin
      valid_d    = 1'b0;
      instr_d    = instr_q;
      pc_d       = pc_q;
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      case (state_q)
        S_REQ: begin
          // A request granted this cycle targets the old PC; drop its response.
          if (req && imem_gnt_i) begin
            discard_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign opcode_o      = instr_q[6:0];
  assign instr_rd_o    = instr_q[11:7];
  assign instr_rs1_o   = instr_q[19:15];
  assign instr_rs2_o   = instr_q[24:20];

endmodule

// File: tb/tb_instr_fetch_32.sv
// Bench for instr_fetch_32: directed scenarios followed by a randomized run
// against a transaction-level model of the instruction stream.
module tb_instr_fetch_32;

  logic        clk;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;
  logic [4:0]  instr_rd_o;
  logic [4:0]  instr_rs1_o;
  logic [4:0]  instr_rs2_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  instr_fetch_32 #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .opcode_o      (opcode_o),
    .instr_rd_o    (instr_rd_o),
    .instr_rs1_o   (instr_rs1_o),
    .instr_rs2_o   (instr_rs2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then apply the inputs for the new cycle and let them settle.
  task automatic step(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                      input logic st, input logic rdr, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst = r; imem_gnt_i = g; imem_rvalid_i = rv; imem_rdata_i = rd;
    stall_i = st; redirect_i = rdr; redirect_pc_i = rpc;
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req_o},    32'd0);
    chk({tag, "_addr"},  imem_addr_o,            32'h0);
    chk({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd0);
    chk({tag, "_instr"}, instr_o,                32'h0);
    chk({tag, "_pc"},    pc_o,                   32'h0);
    chk({tag, "_fields"}, {5'b0, opcode_o, instr_rd_o, instr_rs1_o, instr_rs2_o}, 32'h0);
  endtask

  // Memory image used by the randomized run: contents are a pure function of address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Randomized-run model state.
  logic [31:0] exp_pc;
  logic [31:0] expw;
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_data;
  logic        prev_rst, prev_redirect, prev_hold;
  logic [31:0] held_instr, held_pc;
  logic [31:0] rtgt;
  int          delivered;

  initial begin
    rst = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Reset state and the basic fetch sequence 0, 4, 8.
    step(0, 0, 0, 0, 0, 0, 0);                     // cycle 0, IDLE
    chk_reset_state("reset");
    step(0, 1, 0, 0, 0, 0, 0);                     // cycle 1
    chk("c1_req", {31'b0, imem_req_o}, 32'd1);
    chk("c1_addr", imem_addr_o, 32'h0);
    step(0, 0, 1, 32'h0050_0093, 0, 0, 0);         // cycle 2, response
    chk("c2_req", {31'b0, imem_req_o}, 32'd0);
    step(0, 1, 0, 0, 0, 0, 0);                     // cycle 3
    chk("c3_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("c3_pc", pc_o, 32'h0);
    chk("c3_opcode", {25'b0, opcode_o}, 32'h13);
    chk("c3_rd", {27'b0, instr_rd_o}, 32'd1);
    chk("c3_rs1", {27'b0, instr_rs1_o}, 32'd0);
    chk("c3_rs2", {27'b0, instr_rs2_o}, 32'd5);
    chk("c3_req", {31'b0, imem_req_o}, 32'd1);
    chk("c3_addr", imem_addr_o, 32'h4);
    step(0, 0, 1, 32'h00A0_0113, 0, 0, 0);         // cycle 4
    chk("c4_valid", {31'b0, instr_valid_o}, 32'd0);

    // Stall for five cycles with a valid output.
    step(0, 0, 0, 0, 1, 0, 0);                     // cycle 5
    chk("c5_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("c5_pc", pc_o, 32'h4);
    chk("c5_rd", {27'b0, instr_rd_o}, 32'd2);
    chk("c5_req", {31'b0, imem_req_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      chk("stall_valid", {31'b0, instr_valid_o}, 32'd1);
      chk("stall_instr", instr_o, 32'h00A0_0113);
      chk("stall_pc", pc_o, 32'h4);
      chk("stall_req", {31'b0, imem_req_o}, 32'd0);
    end
    step(0, 1, 0, 0, 0, 0, 0);                     // cycle 10, release
    chk("release_req", {31'b0, imem_req_o}, 32'd1);
    chk("release_addr", imem_addr_o, 32'h8);

    // Redirect to 0x103 while waiting; late response must be dropped.
    step(0, 0, 0, 0, 0, 1, 32'h0000_0103);         // cycle 11
    chk("c11_valid", {31'b0, instr_valid_o}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("c12_req", {31'b0, imem_req_o}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("c13_valid", {31'b0, instr_valid_o}, 32'd0);
    step(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);         // cycle 14
    chk("c14_req", {31'b0, imem_req_o}, 32'd0);
    step(0, 1, 0, 0, 0, 0, 0);                     // cycle 15
    chk("drop_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("redir_req", {31'b0, imem_req_o}, 32'd1);
    chk("redir_addr", imem_addr_o, 32'h100);
    step(0, 0, 1, 32'h0041_8193, 0, 0, 0);         // cycle 16
    step(0, 0, 0, 0, 1, 0, 0);                     // cycle 17, stalled
    chk("c17_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("c17_pc", pc_o, 32'h100);
    chk("c17_instr", instr_o, 32'h0041_8193);

    // Reset with a valid output held; stale rvalid afterwards is ignored.
    step(1, 0, 0, 0, 1, 0, 0);                     // cycle 18
    chk("c18_valid", {31'b0, instr_valid_o}, 32'd1);
    step(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);         // cycle 19, IDLE
    chk_reset_state("rst_valid");
    step(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);         // cycle 20, REQ
    chk("c20_req", {31'b0, imem_req_o}, 32'd1);
    chk("c20_addr", imem_addr_o, 32'h0);
    step(0, 1, 0, 0, 0, 0, 0);                     // cycle 21, still REQ
    chk("stale_req", {31'b0, imem_req_o}, 32'd1);
    chk("stale_valid", {31'b0, instr_valid_o}, 32'd0);
    step(0, 0, 1, 32'h0050_0093, 0, 0, 0);         // cycle 22
    step(0, 1, 0, 0, 0, 0, 0);                     // cycle 23
    chk("c23_pc", pc_o, 32'h0);
    chk("c23_addr", imem_addr_o, 32'h4);
    step(0, 0, 1, 32'h00A0_0113, 0, 0, 0);         // cycle 24

    // Redirect to 0x40 in the same cycle as the grant for 0x8.
    step(0, 1, 0, 0, 0, 1, 32'h0000_0040);         // cycle 25
    chk("c25_pc", pc_o, 32'h4);
    chk("c25_addr", imem_addr_o, 32'h8);
    chk("c25_req", {31'b0, imem_req_o}, 32'd1);
    step(0, 0, 1, 32'hBAD0_BAD0, 0, 0, 0);         // cycle 26
    chk("c26_valid", {31'b0, instr_valid_o}, 32'd0);
    step(0, 1, 0, 0, 0, 0, 0);                     // cycle 27
    chk("gntredir_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("gntredir_addr", imem_addr_o, 32'h40);
    step(0, 0, 1, 32'h00C0_0213, 0, 0, 0);         // cycle 28

    // Redirect near the top of memory and check the PC wraps.
    step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE);         // cycle 29
    chk("c29_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("c29_pc", pc_o, 32'h40);
    chk("c29_instr", instr_o, 32'h00C0_0213);
    chk("c29_rd", {27'b0, instr_rd_o}, 32'd4);
    step(0, 1, 0, 0, 0, 0, 0);                     // cycle 30
    chk("top_addr", imem_addr_o, 32'hFFFF_FFFC);
    step(0, 0, 1, 32'h0010_0513, 0, 0, 0);         // cycle 31
    step(0, 1, 0, 0, 0, 0, 0);                     // cycle 32
    chk("top_pc", pc_o, 32'hFFFF_FFFC);
    chk("top_instr", instr_o, 32'h0010_0513);
    chk("wrap_addr", imem_addr_o, 32'h0);

    // Reset while a request is outstanding.
    step(1, 0, 0, 0, 0, 0, 0);                     // cycle 33, WAIT
    chk("c33_req", {31'b0, imem_req_o}, 32'd0);
    step(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);         // cycle 34, IDLE
    chk_reset_state("rst_wait");
    step(0, 0, 0, 0, 0, 0, 0);                     // cycle 35, REQ
    chk("c35_req", {31'b0, imem_req_o}, 32'd1);
    chk("c35_addr", imem_addr_o, 32'h0);

    // Randomized run: DUT is in REQ for RESET_PC with nothing outstanding.
    exp_pc = 32'h0; pend = 1'b0; pend_cnt = 0; pend_data = 32'h0;
    prev_rst = 1'b0; prev_redirect = 1'b0; prev_hold = 1'b0;
    held_instr = 32'h0; held_pc = 32'h0; delivered = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      rst = ($urandom % 400) == 0;
      stall_i = ($urandom % 4) == 0;
      redirect_i = ($urandom % 16) == 0;
      rtgt = $urandom;
      if (($urandom % 4) == 0) rtgt = 32'hFFFF_FFF0 | (rtgt & 32'hF);
      redirect_pc_i = rtgt;
      imem_gnt_i = $urandom % 2;
      if (pend && pend_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i = pend_data;
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i = $urandom;
        if (pend) pend_cnt--;
      end
      #1;

      if (prev_rst) begin
        chk("r_rst_valid", {31'b0, instr_valid_o}, 32'd0);
        chk("r_rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("r_rst_addr", imem_addr_o, 32'h0);
        chk("r_rst_pc", pc_o, 32'h0);
      end
      if (prev_redirect) chk("r_redir_valid", {31'b0, instr_valid_o}, 32'd0);
      if (prev_hold) begin
        chk("r_hold_valid", {31'b0, instr_valid_o}, 32'd1);
        chk("r_hold_instr", instr_o, held_instr);
        chk("r_hold_pc", pc_o, held_pc);
      end
      if (instr_valid_o) begin
        expw = mem(exp_pc);
        chk("r_pc", pc_o, exp_pc);
        chk("r_instr", instr_o, expw);
        chk("r_fields", {5'b0, opcode_o, instr_rd_o, instr_rs1_o, instr_rs2_o},
            {5'b0, expw[6:0], expw[11:7], expw[19:15], expw[24:20]});
        if (stall_i) chk("r_stall_req", {31'b0, imem_req_o}, 32'd0);
      end
      if (pend) chk("r_outstanding_req", {31'b0, imem_req_o}, 32'd0);
      if (imem_req_o) chk("r_addr_align", {30'b0, imem_addr_o[1:0]}, 32'd0);

      // Effects of the coming clock edge on the expected stream.
      prev_hold = !rst && !redirect_i && instr_valid_o && stall_i;
      held_instr = instr_o;
      held_pc = pc_o;
      prev_rst = rst;
      prev_redirect = !rst && redirect_i;
      if (rst) begin
        exp_pc = 32'h0;
        pend = 1'b0;
      end else begin
        if (instr_valid_o && !stall_i) begin
          delivered++;
          $display("txn %0d pc=%h instr=%h", delivered, pc_o, instr_o);
        end
        if (redirect_i) exp_pc = {redirect_pc_i[31:2], 2'b00};
        else if (instr_valid_o && !stall_i) exp_pc = exp_pc + 32'd4;
        if (imem_rvalid_i) pend = 1'b0;
        if (imem_req_o && imem_gnt_i) begin
          pend = 1'b1;
          pend_cnt = $urandom_range(0, 2);
          pend_data = mem(imem_addr_o);
        end
      end
    end
    chk("progress", {31'b0, delivered > 100}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
